// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, ALU/immediate/writeback enums and the immediate generator.
// Pure definitions: no state, no timing.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LSB  = 3'd0;
    localparam logic [2:0] F3_LSH  = 3'd1;
    localparam logic [2:0] F3_LSW  = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] insn, input imm_fmt_t fmt);
        case (fmt)
            IMM_S:   imm_gen = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm_gen = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm_gen = {insn[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm_gen = {{20{insn[31]}}, insn[31:20]};
        endcase
    endfunction

    // alt selects SUB/SRA; the caller only raises it where funct7 is meaningful.
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  f3_to_alu = ALU_SLL;
            F3_SLT:  f3_to_alu = ALU_SLT;
            F3_SLTU: f3_to_alu = ALU_SLTU;
            F3_XOR:  f3_to_alu = ALU_XOR;
            F3_SR:   f3_to_alu = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   f3_to_alu = ALU_OR;
            default: f3_to_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file, two combinational read ports, one write port at posedge; x0 reads zero.
// Writes land at the next posedge; synchronous active-low clear of all registers; never stalls.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with internal instruction ROM and data RAM; one instruction retires per clock.
// Zero-latency fetch/execute, commit at posedge, no stalls. Define CPU_TRACE_EN for a per-retire trace line.
module rv32i_cpu
    import rv32i_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter string       IMEM_INIT  = "",
    parameter string       DMEM_INIT  = "",
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic clk,
    input  logic rst
);
    localparam int IA = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DA = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    initial begin
        for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
    end

    logic [31:0] pc, pc4, next_pc, insn, imm, rs1_val, rs2_val;
    logic [31:0] alu_a, alu_b, alu_y, br_target, ld_word, ld_val, wd, st_data;
    logic [IA-1:0] i_idx;
    logic [DA-1:0] d_idx;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_mask;
    logic        a_pc, b_imm, reg_we, mem_we, is_br, is_jal, is_jalr, br_taken;
    alu_op_t     alu_op;
    imm_fmt_t    imm_fmt;
    wb_sel_t     wb_sel;

    assign i_idx  = IA'(pc[31:2] % IMEM_WORDS);
    assign insn   = imem[i_idx];
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign imm    = imm_gen(insn, imm_fmt);
    assign pc4    = pc + 32'd4;

    rv32i_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (reg_we),
        .wa  (rd),
        .wd  (wd)
    );

    // Unlisted opcodes fall through the defaults: PC+4 with no writes.
    always_comb begin
        imm_fmt = IMM_I;
        alu_op  = ALU_ADD;
        a_pc    = 1'b0;
        b_imm   = 1'b1;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        wb_sel  = WB_ALU;
        is_br   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        case (opcode)
            OP_LUI:    begin imm_fmt = IMM_U; alu_op = ALU_PASSB; reg_we = 1'b1; end
            OP_AUIPC:  begin imm_fmt = IMM_U; a_pc = 1'b1; reg_we = 1'b1; end
            OP_JAL:    begin imm_fmt = IMM_J; is_jal = 1'b1; reg_we = 1'b1; wb_sel = WB_PC4; end
            OP_JALR:   begin is_jalr = 1'b1; reg_we = 1'b1; wb_sel = WB_PC4; end
            OP_BRANCH: begin imm_fmt = IMM_B; is_br = 1'b1; b_imm = 1'b0; end
            OP_LOAD:   begin reg_we = 1'b1; wb_sel = WB_MEM; end
            OP_STORE:  begin imm_fmt = IMM_S; mem_we = 1'b1; end
            OP_IMM:    begin alu_op = f3_to_alu(f3, insn[30] && f3 == F3_SR); reg_we = 1'b1; end
            OP_REG:    begin alu_op = f3_to_alu(f3, insn[30]); b_imm = 1'b0; reg_we = 1'b1; end
            default: ;
        endcase
    end

    assign alu_a = a_pc ? pc : rs1_val;
    assign alu_b = b_imm ? imm : rs2_val;

    always_comb begin
        case (alu_op)
            ALU_SUB:   alu_y = alu_a - alu_b;
            ALU_SLL:   alu_y = alu_a << alu_b[4:0];
            ALU_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:   alu_y = alu_a ^ alu_b;
            ALU_SRL:   alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:   alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:    alu_y = alu_a | alu_b;
            ALU_AND:   alu_y = alu_a & alu_b;
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign br_target = pc + imm;

    always_comb begin
        next_pc = pc4;
        if (is_jal || (is_br && br_taken)) next_pc = br_target;
        else if (is_jalr)                  next_pc = alu_y & ~32'd1;
    end

    // Misaligned halves/words simply use addr[1] or the word address; no split access.
    assign d_idx   = DA'(alu_y[31:2] % DMEM_WORDS);
    assign ld_word = dmem[d_idx];
    assign ld_byte = ld_word[{alu_y[1:0], 3'b000} +: 8];
    assign ld_half = alu_y[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        case (f3)
            F3_LSB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3_LSH:  ld_val = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_val = {24'd0, ld_byte};
            F3_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        st_data = rs2_val;
        st_mask = 4'b0000;
        case (f3)
            F3_LSB:  begin st_data = {4{rs2_val[7:0]}};  st_mask = 4'b0001 << alu_y[1:0]; end
            F3_LSH:  begin st_data = {2{rs2_val[15:0]}}; st_mask = alu_y[1] ? 4'b1100 : 4'b0011; end
            F3_LSW:  st_mask = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  wd = ld_val;
            WB_PC4:  wd = pc4;
            default: wd = alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= next_pc;
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask[b]) dmem[d_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

`ifdef CPU_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if (mem_we) $display("STORE [%h] <= %h", alu_y, rs2_val);
            else        $display("PC=%h INSN=%h rd=x%0d <= %h", pc, insn, reg_we ? rd : 5'd0, wd);
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_cpu.sv
// Directed programs loaded into the instruction ROM; expected architectural state is queued
// by the stimulus process and compared by a separate monitor on the falling edge.
module tb_rv32i_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rv32i_cpu #(
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024),
        .IMEM_INIT  (""),
        .DMEM_INIT  (""),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    localparam int K_REG = 0;
    localparam int K_PC  = 1;
    localparam int K_MEM = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    logic chk_vld = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always @(negedge clk) begin
        if (chk_vld) begin
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.kind)
                    K_REG:   act = dut.u_rf.regs[e.idx];
                    K_PC:    act = dut.pc;
                    default: act = dut.dmem[e.idx];
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic flush();
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.imem[i] = NOP;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
    endtask

    initial begin
        // addi chain and reset state
        clear_imem();
        dut.imem[0] = 32'h00500093;   // addi x1,x0,5
        dut.imem[1] = 32'hFF908113;   // addi x2,x1,-7
        rst = 1'b0;
        run(2);
        expect_val("reset_pc", K_PC, 0, 32'h0);
        expect_val("reset_x1", K_REG, 1, 32'h0);
        expect_val("reset_x31", K_REG, 31, 32'h0);
        flush();
        rst = 1'b1;
        run(2);
        expect_val("addi_x1", K_REG, 1, 32'd5);
        expect_val("addi_x2", K_REG, 2, 32'hFFFFFFFE);
        expect_val("addi_pc", K_PC, 0, 32'd8);
        flush();

        // loads and stores, byte/half lanes and sign extension
        clear_imem();
        dut.imem[0]  = 32'h123451B7;  // lui  x3,0x12345
        dut.imem[1]  = 32'h67818193;  // addi x3,x3,0x678
        dut.imem[2]  = 32'h00302423;  // sw   x3,8(x0)
        dut.imem[3]  = 32'h00900203;  // lb   x4,9(x0)
        dut.imem[4]  = 32'h00B04283;  // lbu  x5,11(x0)
        dut.imem[5]  = 32'hF8000413;  // addi x8,x0,-128
        dut.imem[6]  = 32'h00800623;  // sb   x8,12(x0)
        dut.imem[7]  = 32'h00C00483;  // lb   x9,12(x0)
        dut.imem[8]  = 32'h00C04503;  // lbu  x10,12(x0)
        dut.imem[9]  = 32'h00301723;  // sh   x3,14(x0)
        dut.imem[10] = 32'h00E01583;  // lh   x11,14(x0)
        do_reset();
        run(11);
        expect_val("lui_addi_x3", K_REG, 3, 32'h12345678);
        expect_val("sw_dmem2", K_MEM, 2, 32'h12345678);
        expect_val("lb_x4", K_REG, 4, 32'h00000056);
        expect_val("lbu_x5", K_REG, 5, 32'h00000012);
        expect_val("lb_neg_x9", K_REG, 9, 32'hFFFFFF80);
        expect_val("lbu_x10", K_REG, 10, 32'h00000080);
        expect_val("sb_sh_dmem3", K_MEM, 3, 32'h56780080);
        expect_val("lh_x11", K_REG, 11, 32'h00005678);
        flush();

        // countdown loop with backward bne
        clear_imem();
        dut.imem[0] = 32'h00300093;   // addi x1,x0,3
        dut.imem[1] = 32'hFFF08093;   // L: addi x1,x1,-1
        dut.imem[2] = 32'hFE009EE3;   // bne x1,x0,L
        do_reset();
        run(3);
        expect_val("loop_taken_pc", K_PC, 0, 32'd4);
        expect_val("loop_mid_x1", K_REG, 1, 32'd2);
        flush();
        run(4);
        expect_val("loop_x1", K_REG, 1, 32'd0);
        expect_val("loop_exit_pc", K_PC, 0, 32'd12);
        flush();

        // jal / jalr including rd==rs1, then auipc
        clear_imem();
        dut.imem[0] = 32'h008000EF;   // jal  x1,+8
        dut.imem[1] = 32'h00C080E7;   // jalr x1,12(x1)
        dut.imem[2] = 32'h00108067;   // jalr x0,1(x1)
        dut.imem[4] = 32'h00001117;   // auipc x2,1
        do_reset();
        run(1);
        expect_val("jal_x1", K_REG, 1, 32'd4);
        expect_val("jal_pc", K_PC, 0, 32'd8);
        flush();
        run(1);
        expect_val("jalr_bit0_pc", K_PC, 0, 32'd4);
        flush();
        run(1);
        expect_val("jalr_same_pc", K_PC, 0, 32'd16);
        expect_val("jalr_same_x1", K_REG, 1, 32'd8);
        flush();
        run(1);
        expect_val("auipc_x2", K_REG, 2, 32'h00001010);
        flush();

        // x0 immutability and illegal opcode
        clear_imem();
        dut.imem[0] = 32'h00900013;   // addi x0,x0,9
        dut.imem[1] = 32'h00000333;   // add  x6,x0,x0
        dut.imem[2] = 32'hFFFFFFFF;   // illegal
        do_reset();
        run(3);
        expect_val("x0_zero", K_REG, 0, 32'h0);
        expect_val("add_x6", K_REG, 6, 32'h0);
        expect_val("illegal_pc", K_PC, 0, 32'd12);
        expect_val("illegal_x31", K_REG, 31, 32'h0);
        expect_val("illegal_dmem3", K_MEM, 3, 32'h56780080);
        flush();

        // shifts, compares, subtract
        clear_imem();
        dut.imem[0] = 32'hFF000093;   // addi x1,x0,-16
        dut.imem[1] = 32'h4020D113;   // srai x2,x1,2
        dut.imem[2] = 32'h01C0D193;   // srli x3,x1,28
        dut.imem[3] = 32'h00103233;   // sltu x4,x0,x1
        dut.imem[4] = 32'h0000A2B3;   // slt  x5,x1,x0
        dut.imem[5] = 32'h40100333;   // sub  x6,x0,x1
        do_reset();
        run(6);
        expect_val("srai_x2", K_REG, 2, 32'hFFFFFFFC);
        expect_val("srli_x3", K_REG, 3, 32'h0000000F);
        expect_val("sltu_x4", K_REG, 4, 32'd1);
        expect_val("slt_x5", K_REG, 5, 32'd1);
        expect_val("sub_x6", K_REG, 6, 32'd16);
        flush();

        // mid-program reset keeps data memory
        clear_imem();
        dut.imem[0] = 32'h00300093;
        dut.imem[1] = 32'hFFF08093;
        dut.imem[2] = 32'hFE009EE3;
        do_reset();
        run(10);
        rst = 1'b0;
        run(1);
        expect_val("midrst_pc", K_PC, 0, 32'h0);
        expect_val("midrst_x1", K_REG, 1, 32'h0);
        expect_val("midrst_dmem2", K_MEM, 2, 32'h12345678);
        expect_val("midrst_dmem3", K_MEM, 3, 32'h56780080);
        flush();
        rst = 1'b1;

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
